// File: rtl/wb_regfile_sink.sv
// Writeback-side register file: 32x32 array, two bypassed read ports for decode,
// and a per-register pending-write scoreboard that generates the decode stall.
module wb_regfile_sink #(
   parameter int unsigned DW           = 32,
   parameter int unsigned MAX_INFLIGHT = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          RegWrite,
   input  logic [4:0]    rd,
   input  logic [DW-1:0] dataout,
   input  logic [4:0]    ra1,
   input  logic [4:0]    ra2,
   output logic [DW-1:0] busA,
   output logic [DW-1:0] busB,
   input  logic          issue_valid,
   input  logic          use_rs1,
   input  logic          use_rs2,
   input  logic          issue_wr,
   input  logic [4:0]    issue_rd,
   output logic          stall,
   output logic          wb_err
);

   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;
   localparam int unsigned CW   = $clog2(MAX_INFLIGHT + 1);

   logic [DW-1:0] regs [NREG];
   logic [CW-1:0] cnt  [NREG];

   logic          wb_live;
   logic          busy1;
   logic          busy2;
   logic          dst_full;
   logic          accept;
   logic          issue_live;
   logic          wb_set;
   logic [NREG-1:0] inc_vec;
   logic [NREG-1:0] dec_vec;

   assign wb_live    = RegWrite && (rd != '0);
   assign issue_live = issue_wr && (issue_rd != '0);

   // Read ports: r0 hardwired to zero, WB data forwarded ahead of the array
   always_comb begin
      busA = regs[ra1];
      if (ra1 == '0) begin
         busA = '0;
      end else if (RegWrite && (rd == ra1)) begin
         busA = dataout;
      end
   end

   always_comb begin
      busB = regs[ra2];
      if (ra2 == '0) begin
         busB = '0;
      end else if (RegWrite && (rd == ra2)) begin
         busB = dataout;
      end
   end

   // An operand whose last pending producer is writing back this cycle is not busy
   always_comb begin
      busy1 = use_rs1 && (ra1 != '0) && (cnt[ra1] != '0);
      if ((cnt[ra1] == CW'(1)) && RegWrite && (rd == ra1)) begin
         busy1 = 1'b0;
      end
   end

   always_comb begin
      busy2 = use_rs2 && (ra2 != '0) && (cnt[ra2] != '0);
      if ((cnt[ra2] == CW'(1)) && RegWrite && (rd == ra2)) begin
         busy2 = 1'b0;
      end
   end

   assign dst_full = issue_live && (cnt[issue_rd] == CW'(MAX_INFLIGHT));
   assign stall    = issue_valid && (busy1 || busy2 || dst_full);
   assign accept   = issue_valid && !stall;

   // A WB with no pending producer is an error unless a same-cycle issue covers it
   assign wb_set = wb_live && (cnt[rd] == '0) &&
                   !(accept && issue_live && (issue_rd == rd));

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 1; i < NREG; i++) begin
         inc_vec[i] = accept && issue_wr && (issue_rd == AW'(i));
         dec_vec[i] = RegWrite && (rd == AW'(i)) && (cnt[i] != '0);
      end
   end

   // Register array
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wb_live) begin
         regs[rd] <= dataout;
      end
   end

   // Pending-write counters; saturation is held off by the stall
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
               cnt[i] <= cnt[i] + CW'(1);
            end else if (dec_vec[i] && !inc_vec[i]) begin
               cnt[i] <= cnt[i] - CW'(1);
            end
         end
      end
   end

   // Sticky WB error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_err <= 1'b0;
      end else if (wb_set) begin
         wb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_regfile_sink.sv
// Directed bench for wb_regfile_sink: per-cycle vector table plus a reset-mid-operation sequence.
module tb_wb_regfile_sink;

   logic        clk;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  rd;
   logic [31:0] dataout;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] busA;
   logic [31:0] busB;
   logic        issue_valid;
   logic        use_rs1;
   logic        use_rs2;
   logic        issue_wr;
   logic [4:0]  issue_rd;
   logic        stall;
   logic        wb_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic        iv;
      logic        u1;
      logic        u2;
      logic        iw;
      logic [4:0]  ird;
      logic [31:0] e_a;
      logic [31:0] e_b;
      logic        e_stall;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   wb_regfile_sink #(.DW(32), .MAX_INFLIGHT(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .RegWrite    (RegWrite),
      .rd          (rd),
      .dataout     (dataout),
      .ra1         (ra1),
      .ra2         (ra2),
      .busA        (busA),
      .busB        (busB),
      .issue_valid (issue_valid),
      .use_rs1     (use_rs1),
      .use_rs2     (use_rs2),
      .issue_wr    (issue_wr),
      .issue_rd    (issue_rd),
      .stall       (stall),
      .wb_err      (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rw, input logic [4:0] wrd, input logic [31:0] data,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic iv, input logic u1, input logic u2,
                               input logic iw, input logic [4:0] ird,
                               input logic [31:0] ea, input logic [31:0] eb,
                               input logic es, input logic ee);
      vec_t v;
      v.rw = rw; v.rd = wrd; v.data = data; v.ra1 = a1; v.ra2 = a2;
      v.iv = iv; v.u1 = u1; v.u2 = u2; v.iw = iw; v.ird = ird;
      v.e_a = ea; v.e_b = eb; v.e_stall = es; v.e_err = ee;
      return v;
   endfunction

   task automatic drive_idle();
      reset = 1'b0; RegWrite = 1'b0; rd = '0; dataout = '0; ra1 = '0; ra2 = '0;
      issue_valid = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; issue_wr = 1'b0; issue_rd = '0;
   endtask

   initial begin
      drive_idle();
      reset = 1'b1;

      //          rw rd  data          ra1 ra2 iv u1 u2 iw ird  expA          expB         st er
      vecs.push_back(mk(0, 0,  32'h0,        5,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0, 1, 0, 0, 1, 3,  32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        3,  0, 1, 1, 0, 0, 0,  32'h0,        32'h0,        1, 0));
      vecs.push_back(mk(1, 3,  32'hDEADBEEF, 3,  0, 1, 1, 0, 0, 0,  32'hDEADBEEF, 32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        3,  3, 1, 1, 1, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0, 1, 0, 0, 1, 7,  32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0, 1, 0, 0, 1, 7,  32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0, 1, 0, 0, 1, 7,  32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(1, 7,  32'h77,       0,  7, 1, 0, 0, 1, 7,  32'h0,        32'h77,       1, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  7, 1, 0, 0, 1, 7,  32'h0,        32'h77,       0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0, 1, 0, 0, 1, 7,  32'h0,        32'h0,        1, 0));
      vecs.push_back(mk(1, 7,  32'h1,        7,  0, 1, 1, 0, 0, 0,  32'h1,        32'h0,        1, 0));
      vecs.push_back(mk(1, 7,  32'h2,        0,  7, 1, 0, 1, 0, 0,  32'h0,        32'h2,        1, 0));
      vecs.push_back(mk(1, 7,  32'h3,        7,  0, 1, 1, 0, 0, 0,  32'h3,        32'h0,        0, 0));
      vecs.push_back(mk(1, 0,  32'hFFFFFFFF, 0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        7,  0, 1, 1, 0, 0, 0,  32'h3,        32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0, 1, 0, 0, 1, 4,  32'h0,        32'h0,        0, 0));
      vecs.push_back(mk(1, 4,  32'h44,       4,  0, 1, 0, 0, 1, 4,  32'h44,       32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        4,  0, 1, 1, 0, 0, 0,  32'h44,       32'h0,        1, 0));
      vecs.push_back(mk(1, 4,  32'h45,       4,  0, 1, 1, 0, 0, 0,  32'h45,       32'h0,        0, 0));
      vecs.push_back(mk(1, 10, 32'hA,        0, 10, 1, 0, 0, 1, 10, 32'h0,        32'hA,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,       10,  0, 1, 1, 0, 0, 0,  32'hA,        32'h0,        1, 0));
      vecs.push_back(mk(1, 10, 32'hB,       10,  0, 1, 1, 0, 0, 0,  32'hB,        32'h0,        0, 0));
      vecs.push_back(mk(1, 9,  32'h99,       9,  0, 0, 0, 0, 0, 0,  32'h99,       32'h0,        0, 0));
      vecs.push_back(mk(0, 0,  32'h0,        9,  0, 0, 0, 0, 0, 0,  32'h99,       32'h0,        0, 1));
      vecs.push_back(mk(0, 0,  32'h0,        0,  0, 0, 0, 0, 0, 0,  32'h0,        32'h0,        0, 1));

      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive_idle();
         RegWrite = vecs[i].rw; rd = vecs[i].rd; dataout = vecs[i].data;
         ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
         issue_valid = vecs[i].iv; use_rs1 = vecs[i].u1; use_rs2 = vecs[i].u2;
         issue_wr = vecs[i].iw; issue_rd = vecs[i].ird;
         #1;
         chk($sformatf("v%0d busA", i), busA, vecs[i].e_a);
         chk($sformatf("v%0d busB", i), busB, vecs[i].e_b);
         chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
         chk($sformatf("v%0d wb_err", i), 32'(wb_err), 32'(vecs[i].e_err));
      end

      // Reset mid-operation: pending r12 discarded, simultaneous WB ignored
      @(negedge clk);
      drive_idle();
      issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd12;
      @(negedge clk);
      drive_idle();
      reset = 1'b1; RegWrite = 1'b1; rd = 5'd9; dataout = 32'h5;
      issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd13;
      @(negedge clk);
      drive_idle();
      ra1 = 5'd9; ra2 = 5'd12; issue_valid = 1'b1; use_rs2 = 1'b1;
      #1;
      chk("rst busA r9", busA, 32'h0);
      chk("rst busB r12", busB, 32'h0);
      chk("rst stall", 32'(stall), 32'h0);
      chk("rst wb_err", 32'(wb_err), 32'h0);
      @(negedge clk);
      drive_idle();
      RegWrite = 1'b1; rd = 5'd12; dataout = 32'h12;
      #1;
      chk("post-rst wb_err before", 32'(wb_err), 32'h0);
      @(negedge clk);
      drive_idle();
      ra1 = 5'd12; issue_valid = 1'b1; use_rs1 = 1'b1;
      #1;
      chk("post-rst wb_err set", 32'(wb_err), 32'h1);
      chk("post-rst busA r12", busA, 32'h12);
      chk("post-rst stall r12", 32'(stall), 32'h0);
      @(negedge clk);
      drive_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_regfile_sink.md
Name: wb_regfile_sink

Overview:
- Consumer end of the writeback interface: the WB stage drives write-enable, write-data and destination index into this block.
- Holds the 32x32 architectural register file with two decode read ports and WB-to-decode write-through bypass.
- Keeps a per-register pending-write scoreboard so decode stalls on operands with in-flight producers.
- Sits between WB (write side) and ID (read/issue side) of the 5-stage core.

Parameters:
- DW, 32, data width of each register
- MAX_INFLIGHT, 3, maximum outstanding writes tracked per register; counter width is 2 bits for the default

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- RegWrite  input  1  WB write enable
- rd  input  5  WB destination register index
- dataout  input  DW  WB write data
- ra1  input  5  decode read address, port 1
- ra2  input  5  decode read address, port 2
- busA  output  DW  read data, port 1
- busB  output  DW  read data, port 2
- issue_valid  input  1  decode presents an instruction this cycle
- use_rs1  input  1  issuing instruction reads ra1
- use_rs2  input  1  issuing instruction reads ra2
- issue_wr  input  1  issuing instruction will write issue_rd
- issue_rd  input  5  destination of issuing instruction
- stall  output  1  issue refused this cycle; decode must hold
- wb_err  output  1  sticky flag: WB wrote a register with zero pending count

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs that cycle):
  - all 32 registers cleared to 0
  - all pending counters cleared to 0
  - wb_err cleared to 0
  - busA/busB read 0 and stall is 0 from the next cycle
- Register write: on the clk edge with RegWrite=1 and rd!=0, reg[rd] takes dataout. Writes to r0 are ignored; r0 always reads 0.
- Read ports are combinational, 0-cycle latency.
  - busX = 0 if raX==0.
  - Otherwise busX = dataout if RegWrite && rd==raX (write-through bypass).
  - Otherwise busX = reg[raX].
- Scoreboard: cnt[i], i=1..31, range 0..MAX_INFLIGHT. cnt[0] is constant 0.
- Operand busy for port X: useX && raX!=0 && cnt[raX]!=0. Exception: not busy when cnt[raX]==1 && RegWrite && rd==raX, because the final producer is bypassed this cycle.
- stall = issue_valid && (busy1 || busy2 || (issue_wr && issue_rd!=0 && cnt[issue_rd]==MAX_INFLIGHT)). This is purely combinational.
- accept = issue_valid && !stall.
- Counter update per edge, for register i:
  - inc = accept && issue_wr && issue_rd==i && i!=0
  - dec = RegWrite && rd==i && i!=0 && cnt[i]!=0
  - inc && dec: unchanged. inc only: +1. dec only: -1.
- wb_err: set when RegWrite && rd!=0 && cnt[rd]==0 and no same-cycle inc to rd would cover it. The write still occurs. The flag stays set until reset.
- Counters never wrap; saturation is prevented by stall.
- Reset mid-operation: pending state is discarded. WB writes arriving after reset with cnt==0 raise wb_err; the pipeline flush on reset must prevent this.
- Issue and WB to the same register in one cycle: the register is written, and the new instruction's pending count replaces the old one (net unchanged).

Test Plan:
- Reset, then read ra1=5, ra2=0 -> busA=0, busB=0, stall=0, wb_err=0.
- Issue writes r3 (accept), then 2 cycles later issue with use_rs1, ra1=3 while cnt[3]=1 and no WB -> stall=1. Next cycle RegWrite=1, rd=3, dataout=0xDEADBEEF -> stall=0, busA=0xDEADBEEF (bypass). Following cycle busA=0xDEADBEEF from the array, cnt[3]=0.
- Three accepted issues writing r7 -> cnt[7]=3. A fourth issue_wr to r7 -> stall=1. A WB to r7 on that cycle -> still stall=1 and cnt[7]=2. Next cycle the issue is accepted -> cnt[7]=3.
- RegWrite=1, rd=0, dataout=0xFFFFFFFF -> busA with ra1=0 stays 0, no counter change, wb_err=0.
- RegWrite=1, rd=9 with cnt[9]=0 -> reg[9] written, wb_err=1 and held. Assert reset -> wb_err=0 and reg[9]=0 next cycle.
- Issue writing r4 and WB to r4 on the same edge with cnt[4]=1 -> cnt[4]=1 after the edge, reg[4]=dataout.
